// File: rtl/register_bank_scoreboard_if.sv
// ============================================================================
// Module   : register_bank_scoreboard_if
// Purpose  : Writeback, issue and read-side bundle for the register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface register_bank_scoreboard_if #(
  parameter int WIDTH = 32
);
  logic                  write_enable;
  logic [3:0]            write_addr;
  logic [WIDTH-1:0]      write_data;
  logic [WIDTH-1:0]      pc_in;
  logic                  issue_valid;
  logic [3:0]            issue_addr;
  logic                  issue_ready;
  logic [16*WIDTH-1:0]   regs_flat;
  logic [15:0]           busy;
  logic                  underflow_err;

  modport master (
    output write_enable, write_addr, write_data, pc_in, issue_valid, issue_addr,
    input  issue_ready, regs_flat, busy, underflow_err
  );

  modport slave (
    input  write_enable, write_addr, write_data, pc_in, issue_valid, issue_addr,
    output issue_ready, regs_flat, busy, underflow_err
  );
endinterface

`default_nettype wire

// File: rtl/register_bank_scoreboard.sv
// ============================================================================
// Module   : register_bank_scoreboard
// Purpose  : R0..R14 storage, R15 = PC, per-register pending-writer counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module register_bank_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  register_bank_scoreboard_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [16*WIDTH-1:0] flat;
  logic [15:0]         busy_vec;
  logic [15:0]         full_vec;
  logic [14:0]         underflow_vec;
  logic                underflow_sticky;
  logic                ready;

  // R15 is not tracked, so it can never be full or busy.
  assign full_vec[15] = 1'b0;
  assign busy_vec[15] = 1'b0;
  assign flat[15*WIDTH +: WIDTH] = bus.pc_in;

  assign ready = ~full_vec[bus.issue_addr];

  generate
    for (genvar i = 0; i < 15; i++) begin : g_reg
      logic [WIDTH-1:0] stored;
      logic [CNT_W-1:0] count;
      logic             inc;
      logic             dec;

      assign inc = bus.issue_valid & ready & (bus.issue_addr == 4'(i));
      assign dec = bus.write_enable & (bus.write_addr == 4'(i));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stored <= '0;
        end else if (dec) begin
          stored <= bus.write_data;
        end
      end

      // Simultaneous issue and writeback cancel out, even at zero.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          count <= '0;
        end else if (inc && !dec) begin
          count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
          count <= count - 1'b1;
        end
      end

      assign underflow_vec[i] = dec & ~inc & (count == '0);
      assign full_vec[i]      = (count == CNT_MAX);
      assign busy_vec[i]      = (count != '0);

      if (BYPASS != 0) begin : g_bypass
        assign flat[i*WIDTH +: WIDTH] = dec ? bus.write_data : stored;
      end else begin : g_nobypass
        assign flat[i*WIDTH +: WIDTH] = stored;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_sticky <= 1'b0;
    end else if (|underflow_vec) begin
      underflow_sticky <= 1'b1;
    end
  end

  assign bus.regs_flat     = flat;
  assign bus.busy          = busy_vec;
  assign bus.issue_ready   = ready;
  assign bus.underflow_err = underflow_sticky;

endmodule

`default_nettype wire

// File: tb/tb_register_bank_scoreboard.sv
// ============================================================================
// Module   : tb_register_bank_scoreboard
// Purpose  : Directed scoreboard bench for register_bank_scoreboard (BYPASS=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_register_bank_scoreboard;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_regs [0:15];
  logic [1:0]       m_cnt  [0:15];
  logic             m_uf;

  register_bank_scoreboard_if #(.WIDTH(WIDTH)) bus ();

  register_bank_scoreboard #(.WIDTH(WIDTH), .CNT_W(2), .BYPASS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [WIDTH-1:0] exp_slice(input int i);
    if (i == 15) return bus.pc_in;
    if (bus.write_enable && bus.write_addr == 4'(i)) return bus.write_data;
    return m_regs[i];
  endfunction

  function automatic logic [WIDTH-1:0] exp_busy();
    logic [WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < 15; i++) b[i] = (m_cnt[i] != 2'd0);
    return b;
  endfunction

  function automatic logic exp_ready();
    if (bus.issue_addr == 4'd15) return 1'b1;
    return m_cnt[bus.issue_addr] != 2'd3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_cnt[i]  = 2'd0;
    end
    m_uf = 1'b0;
  endtask

  // Applies the pre-edge inputs to the model as one clock edge.
  task automatic model_edge();
    logic rdy;
    rdy = exp_ready();
    for (int i = 0; i < 15; i++) begin
      logic inc, dec;
      inc = bus.issue_valid && rdy && bus.issue_addr == 4'(i);
      dec = bus.write_enable && bus.write_addr == 4'(i);
      if (dec) m_regs[i] = bus.write_data;
      if (inc && !dec) m_cnt[i] = m_cnt[i] + 2'd1;
      else if (dec && !inc) begin
        if (m_cnt[i] == 2'd0) m_uf = 1'b1;
        else m_cnt[i] = m_cnt[i] - 2'd1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs);
    logic [WIDTH-1:0] e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_slice(i));
    exp_q.push_back(exp_busy());
    exp_q.push_back(WIDTH'(m_uf));
    exp_q.push_back(WIDTH'(exp_ready()));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_r%0d", tag, i), bus.regs_flat[i*WIDTH +: WIDTH]);
    chk({tag, "_busy"}, WIDTH'(bus.busy));
    chk({tag, "_uf"}, WIDTH'(bus.underflow_err));
    chk({tag, "_ready"}, WIDTH'(bus.issue_ready));
  endtask

  task automatic idle();
    bus.write_enable = 1'b0;
    bus.issue_valid  = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational view, clock, check result.
  task automatic step(input string tag, input logic we, input logic [3:0] wa,
                      input logic [WIDTH-1:0] wd, input logic iv,
                      input logic [3:0] ia);
    @(negedge clk);
    bus.write_enable = we;
    bus.write_addr   = wa;
    bus.write_data   = wd;
    bus.issue_valid  = iv;
    bus.issue_addr   = ia;
    #1;
    check_all({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1;
    idle();
    #1;
    check_all({tag, "_post"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    reset            = 1'b1;
    bus.pc_in        = 32'h0000_0100;
    bus.write_enable = 1'b1;
    bus.write_addr   = 4'd3;
    bus.write_data   = 32'hFFFF_FFFF;
    bus.issue_valid  = 1'b1;
    bus.issue_addr   = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check_all("reset");
    reset = 1'b0;

    step("wr3", 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0);
    step("wr15", 1'b1, 4'd15, 32'h0000_1234, 1'b1, 4'd15);

    step("iss5a", 1'b0, 4'd0, '0, 1'b1, 4'd5);
    step("iss5b", 1'b0, 4'd0, '0, 1'b1, 4'd5);
    step("iss5c", 1'b0, 4'd0, '0, 1'b1, 4'd5);
    step("iss5full", 1'b0, 4'd0, '0, 1'b1, 4'd5);
    step("wb5a", 1'b1, 4'd5, 32'h0000_0051, 1'b0, 4'd5);
    step("wb5b", 1'b1, 4'd5, 32'h0000_0052, 1'b0, 4'd5);
    step("wb5c", 1'b1, 4'd5, 32'h0000_0053, 1'b0, 4'd5);

    step("iss7", 1'b0, 4'd0, '0, 1'b1, 4'd7);
    step("both7", 1'b1, 4'd7, 32'h0000_0077, 1'b1, 4'd7);
    step("wb7", 1'b1, 4'd7, 32'h0000_0078, 1'b0, 4'd0);

    step("uf2", 1'b1, 4'd2, 32'h0000_0022, 1'b0, 4'd0);
    step("wr4", 1'b1, 4'd4, 32'h0000_00AA, 1'b0, 4'd0);
    step("iss4", 1'b0, 4'd0, '0, 1'b1, 4'd4);

    // Asynchronous reset landing between clock edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;

    step("after_rst", 1'b1, 4'd9, 32'h0000_0099, 1'b1, 4'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
